shot_launcher: RTL



---
 rtl/shot_launcher.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/shot_launcher.sv
// Shot launcher: waits, launches a shot at a random lane, animates it toward
// the goal line and reports goal or save with one-cycle pulses.
module shot_launcher #(
   parameter int unsigned SPAWN_DELAY = 32'd15000000,
   parameter int unsigned STEP_DELAY  = 32'd250000,
   parameter int unsigned SHOT_SPEED  = 32'd4,
   parameter int unsigned X_OFFSET    = 32'd64,
   parameter int unsigned Y_START     = 32'd0,
   parameter int unsigned Y_END       = 32'd440
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic [8:0] random_x,
   input  logic       save,
   output logic [9:0] shot_x,
   output logic [9:0] shot_y,
   output logic       shot_active,
   output logic       goal_pulse,
   output logic       save_pulse,
   output logic [7:0] goal_count
);

   localparam int unsigned WAIT_W = (SPAWN_DELAY > 32'd1) ? $clog2(SPAWN_DELAY) : 1;
   localparam int unsigned STEP_W = (STEP_DELAY > 32'd1) ? $clog2(STEP_DELAY) : 1;

   localparam logic [WAIT_W-1:0] WAIT_ZERO = WAIT_W'(32'd0);
   localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(32'd1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SPAWN_DELAY - 32'd1);
   localparam logic [STEP_W-1:0] STEP_ZERO = STEP_W'(32'd0);
   localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(32'd1);
   localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_DELAY - 32'd1);
   localparam logic [9:0]        X_OFF_V   = 10'(X_OFFSET);
   localparam logic [9:0]        Y_START_V = 10'(Y_START);
   localparam logic [9:0]        Y_END_V   = 10'(Y_END);
   localparam logic [10:0]       Y_END_W   = 11'(Y_END);
   localparam logic [10:0]       SPEED_W   = 11'(SHOT_SPEED);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAIT   = 2'd1,
      ST_FLY    = 2'd2,
      ST_RESULT = 2'd3
   } state_t;

   state_t              state_r, state_s;
   logic [WAIT_W-1:0]   wait_cnt_r, wait_cnt_s;
   logic [STEP_W-1:0]   step_cnt_r, step_cnt_s;
   logic [9:0]          shot_x_r, shot_x_s;
   logic [9:0]          shot_y_r, shot_y_s;
   logic                active_r, active_s;
   logic                goal_pulse_r, goal_pulse_s;
   logic                save_pulse_r, save_pulse_s;
   logic [7:0]          goal_count_r, goal_count_s;
   logic [10:0]         y_sum_s;

   // state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // counters and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wait_cnt_r   <= WAIT_ZERO;
         step_cnt_r   <= STEP_ZERO;
         shot_x_r     <= 10'd0;
         shot_y_r     <= Y_START_V;
         active_r     <= 1'b0;
         goal_pulse_r <= 1'b0;
         save_pulse_r <= 1'b0;
         goal_count_r <= 8'd0;
      end else begin
         wait_cnt_r   <= wait_cnt_s;
         step_cnt_r   <= step_cnt_s;
         shot_x_r     <= shot_x_s;
         shot_y_r     <= shot_y_s;
         active_r     <= active_s;
         goal_pulse_r <= goal_pulse_s;
         save_pulse_r <= save_pulse_s;
         goal_count_r <= goal_count_s;
      end
   end

   // next-state and next-datapath logic; pulses default low every cycle
   always_comb begin
      state_s      = state_r;
      wait_cnt_s   = wait_cnt_r;
      step_cnt_s   = step_cnt_r;
      shot_x_s     = shot_x_r;
      shot_y_s     = shot_y_r;
      active_s     = active_r;
      goal_pulse_s = 1'b0;
      save_pulse_s = 1'b0;
      goal_count_s = goal_count_r;
      y_sum_s      = {1'b0, shot_y_r} + SPEED_W;

      case (state_r)
         ST_IDLE: begin
            wait_cnt_s = WAIT_ZERO;
            step_cnt_s = STEP_ZERO;
            active_s   = 1'b0;
            if (enable) begin
               state_s = ST_WAIT;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (!enable) begin
               state_s    = ST_IDLE;
               wait_cnt_s = WAIT_ZERO;
               step_cnt_s = STEP_ZERO;
               active_s   = 1'b0;
            end else if (wait_cnt_r == WAIT_LAST) begin
               state_s    = ST_FLY;
               wait_cnt_s = WAIT_ZERO;
               step_cnt_s = STEP_ZERO;
               shot_x_s   = X_OFF_V + {1'b0, random_x};
               shot_y_s   = Y_START_V;
               active_s   = 1'b1;
            end else begin
               wait_cnt_s = wait_cnt_r + WAIT_ONE;
            end
         end
         ST_FLY: begin
            // disable beats save, save beats a goal step on the same edge
            if (!enable) begin
               state_s    = ST_IDLE;
               wait_cnt_s = WAIT_ZERO;
               step_cnt_s = STEP_ZERO;
               active_s   = 1'b0;
            end else if (save) begin
               state_s      = ST_RESULT;
               step_cnt_s   = STEP_ZERO;
               active_s     = 1'b0;
               save_pulse_s = 1'b1;
            end else if (step_cnt_r == STEP_LAST) begin
               step_cnt_s = STEP_ZERO;
               if (y_sum_s >= Y_END_W) begin
                  state_s      = ST_RESULT;
                  shot_y_s     = Y_END_V;
                  active_s     = 1'b0;
                  goal_pulse_s = 1'b1;
                  goal_count_s = (goal_count_r == 8'd255) ? goal_count_r : goal_count_r + 8'd1;
               end else begin
                  shot_y_s = y_sum_s[9:0];
               end
            end else begin
               step_cnt_s = step_cnt_r + STEP_ONE;
            end
         end
         ST_RESULT: begin
            wait_cnt_s = WAIT_ZERO;
            step_cnt_s = STEP_ZERO;
            active_s   = 1'b0;
            if (enable) begin
               state_s = ST_WAIT;
            end else begin
               state_s = ST_IDLE;
            end
         end
         default: begin
            state_s    = ST_IDLE;
            wait_cnt_s = WAIT_ZERO;
            step_cnt_s = STEP_ZERO;
            active_s   = 1'b0;
         end
      endcase
   end

   assign shot_x      = shot_x_r;
   assign shot_y      = shot_y_r;
   assign shot_active = active_r;
   assign goal_pulse  = goal_pulse_r;
   assign save_pulse  = save_pulse_r;
   assign goal_count  = goal_count_r;

endmodule
